// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared types for the IF/DM backing-memory arbiter:
//   - sequencer state encoding (IDLE / ISSUE / RESP)
//   - grant encoding (GNT_IF / GNT_DM)
//   - default bus widths
//   - debug snapshot struct exported on the top-level dbg_o port
package mem_port_arbiter_pkg;

  localparam int DEFAULT_ADDR_W = 32;
  localparam int DEFAULT_DATA_W = 32;

  // Wide enough for STARVE_MAX in 1..15.
  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_e;

  typedef struct packed {
    arb_state_e          state;
    gnt_e                gnt;
    logic [STARVE_W-1:0] starve_cnt;
    logic                cancel_pending;
  } arb_dbg_t;

endpackage

// File: rtl/mem_port_arbiter_prio_sel.sv
// arb_prio_sel
// DM-first priority selection with an anti-starvation override for IF,
// plus the saturating count of consecutive IF losses.
// Ports:
//   clk_i, rst_i     clock, asynchronous active-high reset
//   arb_en_i         1 while the sequencer is in IDLE and may grant
//   if_req_i         IF request (already masked by a same-cycle cancel)
//   dm_req_i         DM request
//   gnt_valid_o      some requester is asking
//   gnt_o            which requester would win this cycle
//   starve_cnt_o     consecutive IF losses, saturating at STARVE_MAX
module arb_prio_sel
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                arb_en_i,
  input  logic                if_req_i,
  input  logic                dm_req_i,
  output logic                gnt_valid_o,
  output gnt_e                gnt_o,
  output logic [STARVE_W-1:0] starve_cnt_o
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    gnt_valid_o = if_req_i | dm_req_i;
    gnt_o       = GNT_IF;
    // DM wins unless IF has already lost STARVE_MAX times in a row.
    if (dm_req_i && !(if_req_i && (starve_cnt_q == STARVE_LIM))) begin
      gnt_o = GNT_DM;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arb_en_i && gnt_valid_o) begin
      if (gnt_o == GNT_IF) begin
        starve_cnt_d = '0;
      end else if (if_req_i && (starve_cnt_q != STARVE_LIM)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt_o = starve_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, variable-latency memory between the pipeline's
// instruction-fetch (IF) and data-memory (DM) ports with an
// IDLE -> ISSUE -> RESP sequencer.
// Optional feature macro: ARB_TIMEOUT_EN (ISSUE-state timeout, err_o pulse).
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   if_req_i/if_addr_i            IF read request, held until if_done_o
//   if_cancel_i                   branch flush; suppresses the IF done
//   if_done_o/if_rdata_o          IF completion pulse and registered word
//   dm_req_i/dm_we_i/dm_addr_i/dm_wdata_i   DM request, held until dm_done_o
//   dm_done_o/dm_rdata_o          DM completion pulse and read data
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o  backing memory request
//   mem_ack_i/mem_rdata_i         one-cycle completion with read data
//   busy_o                        sequencer not in IDLE
//   err_o                         timeout pulse (0 without ARB_TIMEOUT_EN)
//   dbg_o                         state / grant / starve count / cancel flag
// Handshake: each requester raises req with stable address/data and holds
// it until it sees its one-cycle done pulse; the memory side holds mem_req_o
// with stable mem_* values until a one-cycle mem_ack_i, whose mem_rdata_i is
// valid in that same cycle.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEFAULT_ADDR_W,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  input  logic              if_cancel_i,
  output logic              if_done_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_done_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o,
  output arb_dbg_t          dbg_o
);

  arb_state_e          state_q, state_d;
  gnt_e                gnt_q, gnt_d;
  logic                cancel_pending_q, cancel_pending_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_done_q, if_done_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dm_done_q, dm_done_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                err_q, err_d;

  logic                if_req_eff;
  logic                sel_valid;
  gnt_e                sel_gnt;
  logic [STARVE_W-1:0] starve_cnt;
  logic                if_suppress;

`ifdef ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // A fetch that is flushed in the cycle it is raised never competes.
  assign if_req_eff = if_req_i & ~if_cancel_i;

  arb_prio_sel #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .arb_en_i     (state_q == ST_IDLE),
    .if_req_i     (if_req_eff),
    .dm_req_i     (dm_req_i),
    .gnt_valid_o  (sel_valid),
    .gnt_o        (sel_gnt),
    .starve_cnt_o (starve_cnt)
  );

  // A cancel seen in the completion cycle itself still suppresses the done.
  assign if_suppress = cancel_pending_q | if_cancel_i;

  always_comb begin
    state_d          = state_q;
    gnt_d            = gnt_q;
    cancel_pending_d = cancel_pending_q;
    mem_req_d        = mem_req_q;
    mem_we_d         = mem_we_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    if_done_d        = 1'b0;
    if_rdata_d       = if_rdata_q;
    dm_done_d        = 1'b0;
    dm_rdata_d       = dm_rdata_q;
    err_d            = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d         = to_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        cancel_pending_d = 1'b0;
        if (sel_valid) begin
          gnt_d     = sel_gnt;
          state_d   = ST_ISSUE;
          mem_req_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
          to_cnt_d  = '0;
`endif
          if (sel_gnt == GNT_IF) begin
            mem_we_d   = 1'b0;
            mem_addr_d = if_addr_i;
          end else begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end
        end
      end

      ST_ISSUE: begin
        if ((gnt_q == GNT_IF) && if_cancel_i) begin
          cancel_pending_d = 1'b1;
        end
        if (mem_ack_i) begin
          mem_req_d = 1'b0;
          state_d   = ST_RESP;
          if (gnt_q == GNT_IF) begin
            // The word is captured even when the done is suppressed.
            if_rdata_d = mem_rdata_i;
            if_done_d  = ~if_suppress;
          end else begin
            if (!mem_we_q) begin
              dm_rdata_d = mem_rdata_i;
            end
            dm_done_d = 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
          // Give up: complete towards the requester with rdata unchanged.
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = ST_RESP;
          if (gnt_q == GNT_IF) begin
            if_done_d = ~if_suppress;
          end else begin
            dm_done_d = 1'b1;
          end
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end

      ST_RESP: begin
        // The done pulse is already on the outputs this cycle; requests are
        // deliberately not sampled so a requester can retarget here.
        state_d          = ST_IDLE;
        cancel_pending_d = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      gnt_q            <= GNT_IF;
      cancel_pending_q <= 1'b0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      if_done_q        <= 1'b0;
      if_rdata_q       <= '0;
      dm_done_q        <= 1'b0;
      dm_rdata_q       <= '0;
      err_q            <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q         <= '0;
`endif
    end else begin
      state_q          <= state_d;
      gnt_q            <= gnt_d;
      cancel_pending_q <= cancel_pending_d;
      mem_req_q        <= mem_req_d;
      mem_we_q         <= mem_we_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      if_done_q        <= if_done_d;
      if_rdata_q       <= if_rdata_d;
      dm_done_q        <= dm_done_d;
      dm_rdata_q       <= dm_rdata_d;
      err_q            <= err_d;
`ifdef ARB_TIMEOUT_EN
      to_cnt_q         <= to_cnt_d;
`endif
    end
  end

  assign if_done_o   = if_done_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_done_o   = dm_done_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

  assign dbg_o.state          = state_q;
  assign dbg_o.gnt            = gnt_q;
  assign dbg_o.starve_cnt     = starve_cnt;
  assign dbg_o.cancel_pending = cancel_pending_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter (STARVE_MAX=2, TIMEOUT=8).
// Cycle numbering: inputs are applied in "cycle 0"; each step() advances to
// 1 ns after the next rising edge, where outputs are sampled and the next
// inputs are applied.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_cancel_i;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic        dm_done_o;
  logic [31:0] dm_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;
  arb_dbg_t    dbg_o;

  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .STARVE_MAX (2),
    .TIMEOUT    (8)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_cancel_i (if_cancel_i),
    .if_done_o   (if_done_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_done_o   (dm_done_o),
    .dm_rdata_o  (dm_rdata_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .dbg_o       (dbg_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    if (mem_req_o !== 1'b0) begin $display("FAIL rst_mem_req: got %b required 0", mem_req_o); n_err++; end
    n_cmp++;
    if (busy_o !== 1'b0) begin $display("FAIL rst_busy: got %b required 0", busy_o); n_err++; end
    n_cmp++;
    if ({if_done_o, dm_done_o, err_o, mem_we_o} !== 4'b0) begin
      $display("FAIL rst_pulses: got %b required 0000", {if_done_o, dm_done_o, err_o, mem_we_o}); n_err++;
    end
    n_cmp++;
    if ({if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o} !== 128'h0) begin
      $display("FAIL rst_data: got %h required 0", {if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o}); n_err++;
    end
    n_cmp++;
    if (dbg_o.starve_cnt !== 4'd0 || dbg_o.gnt !== GNT_IF || dbg_o.state !== ST_IDLE) begin
      $display("FAIL rst_dbg: got %h required state IDLE gnt IF starve 0", dbg_o); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_reset_mid_issue();
    if_req_i = 1'b1; if_addr_i = 32'h40;
    step();  // cycle 1: ISSUE
    if (mem_req_o !== 1'b1) begin $display("FAIL rmid_req_before: got %b required 1", mem_req_o); n_err++; end
    n_cmp++;
    rst_i = 1'b1; if_req_i = 1'b0;
    #1;      // asynchronous: no edge needed
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || mem_addr_o !== 32'h0) begin
      $display("FAIL rmid_async: got req %b busy %b addr %h required 0 0 0", mem_req_o, busy_o, mem_addr_o); n_err++;
    end
    n_cmp++;
    step();
    rst_i = 1'b0;
    step();  // late ack arrives two cycles after the reset
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF0000;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b0 || if_rdata_o !== 32'h0 || busy_o !== 1'b0) begin
      $display("FAIL rmid_late_ack: got done %b rdata %h busy %b required 0 0 0", if_done_o, if_rdata_o, busy_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b1; if_addr_i = 32'h44;
    step();
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h44) begin
      $display("FAIL rmid_fresh_issue: got req %b addr %h required 1 00000044", mem_req_o, mem_addr_o); n_err++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h12345678;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'h12345678) begin
      $display("FAIL rmid_fresh_done: got done %b rdata %h required 1 12345678", if_done_o, if_rdata_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    if_req_i = 1'b1; if_addr_i = 32'h10;
    for (int c = 1; c <= 3; c++) begin
      step();
      if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h10 || mem_we_o !== 1'b0) begin
        $display("FAIL ifrd_req_c%0d: got req %b addr %h we %b required 1 00000010 0", c, mem_req_o, mem_addr_o, mem_we_o); n_err++;
      end
      n_cmp++;
    end
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEADBEEF;  // ack on the 3rd request cycle
    step();  // cycle 4
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'hDEADBEEF || mem_req_o !== 1'b0) begin
      $display("FAIL ifrd_done_c4: got done %b rdata %h req %b required 1 deadbeef 0", if_done_o, if_rdata_o, mem_req_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0;
    step();  // cycle 5
    if (if_done_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL ifrd_idle_c5: got done %b busy %b required 0 0", if_done_o, busy_o); n_err++;
    end
    n_cmp++;
  endtask

  task automatic test_dm_priority();
    if_req_i = 1'b1; if_addr_i = 32'h30;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h20; dm_wdata_i = 32'h5;
    step();  // cycle 1
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h20 || mem_wdata_o !== 32'h5) begin
      $display("FAIL prio_dm_first: got req %b we %b addr %h wdata %h required 1 1 00000020 00000005",
               mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o); n_err++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hBAD0BAD0;  // must not reach dm_rdata_o
    step();  // cycle 2
    mem_ack_i = 1'b0;
    if (dm_done_o !== 1'b1 || if_done_o !== 1'b0) begin
      $display("FAIL prio_dm_done_c2: got dm %b if %b required 1 0", dm_done_o, if_done_o); n_err++;
    end
    n_cmp++;
    if (dm_rdata_o !== 32'h0) begin
      $display("FAIL prio_wr_rdata: got %h required 00000000", dm_rdata_o); n_err++;
    end
    n_cmp++;
    dm_req_i = 1'b0; dm_we_i = 1'b0;
    step();  // cycle 3: IDLE
    if (mem_req_o !== 1'b0 || dbg_o.starve_cnt !== 4'd1) begin
      $display("FAIL prio_idle_c3: got req %b starve %0d required 0 1", mem_req_o, dbg_o.starve_cnt); n_err++;
    end
    n_cmp++;
    step();  // cycle 4
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h30 || mem_we_o !== 1'b0) begin
      $display("FAIL prio_if_c4: got req %b addr %h we %b required 1 00000030 0", mem_req_o, mem_addr_o, mem_we_o); n_err++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'hA5A5A5A5;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b1 || if_rdata_o !== 32'hA5A5A5A5 || dbg_o.starve_cnt !== 4'd0) begin
      $display("FAIL prio_if_done: got done %b rdata %h starve %0d required 1 a5a5a5a5 0",
               if_done_o, if_rdata_o, dbg_o.starve_cnt); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0;
    step();
  endtask

  task automatic test_starvation();
    logic [31:0] rd_tab [2];
    rd_tab[0] = 32'h11; rd_tab[1] = 32'h22;
    if_req_i = 1'b1; if_addr_i = 32'h50;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h60;
    for (int r = 0; r < 2; r++) begin
      step();  // ISSUE, DM wins
      if (mem_addr_o !== 32'h60 || dbg_o.starve_cnt !== 4'(r + 1)) begin
        $display("FAIL starve_dm_win%0d: got addr %h starve %0d required 00000060 %0d", r, mem_addr_o, dbg_o.starve_cnt, r + 1); n_err++;
      end
      n_cmp++;
      mem_ack_i = 1'b1; mem_rdata_i = rd_tab[r];
      step();  // RESP
      mem_ack_i = 1'b0;
      if (dm_done_o !== 1'b1 || dm_rdata_o !== rd_tab[r]) begin
        $display("FAIL starve_dm_done%0d: got done %b rdata %h required 1 %h", r, dm_done_o, dm_rdata_o, rd_tab[r]); n_err++;
      end
      n_cmp++;
      step();  // IDLE, both still requesting
    end
    step();    // third arbitration goes to IF
    if (mem_addr_o !== 32'h50 || dbg_o.gnt !== GNT_IF || dbg_o.starve_cnt !== 4'd0) begin
      $display("FAIL starve_if_win: got addr %h gnt %b starve %0d required 00000050 IF 0",
               mem_addr_o, dbg_o.gnt, dbg_o.starve_cnt); n_err++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h33;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b1 || dm_done_o !== 1'b0) begin
      $display("FAIL starve_if_done: got if %b dm %b required 1 0", if_done_o, dm_done_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0; dm_req_i = 1'b0;
    step();
  endtask

  task automatic test_cancel();
    // Cancel in the same cycle as the ack.
    if_req_i = 1'b1; if_addr_i = 32'h70;
    step();  // cycle 1
    step();  // cycle 2
    mem_ack_i = 1'b1; mem_rdata_i = 32'h70707070; if_cancel_i = 1'b1; if_req_i = 1'b0;
    step();  // cycle 3
    mem_ack_i = 1'b0; if_cancel_i = 1'b0;
    if (if_done_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("FAIL cancel_ack_done: got done %b busy %b required 0 1", if_done_o, busy_o); n_err++;
    end
    n_cmp++;
    step();  // cycle 4: two cycles after the ack
    if (busy_o !== 1'b0 || if_done_o !== 1'b0) begin
      $display("FAIL cancel_ack_idle: got busy %b done %b required 0 0", busy_o, if_done_o); n_err++;
    end
    n_cmp++;
    // Cancel earlier in ISSUE, ack later.
    if_req_i = 1'b1; if_addr_i = 32'h74;
    step();
    if_cancel_i = 1'b1; if_req_i = 1'b0;
    step();
    if_cancel_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h7;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b0) begin
      $display("FAIL cancel_early: got done %b required 0", if_done_o); n_err++;
    end
    n_cmp++;
    step();
    // Cancel during a DM grant is ignored.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h90;
    step();
    if_cancel_i = 1'b1;
    step();
    if_cancel_i = 1'b0;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h600DF00D;
    step();
    mem_ack_i = 1'b0;
    if (dm_done_o !== 1'b1 || dm_rdata_o !== 32'h600DF00D) begin
      $display("FAIL cancel_dm_noeffect: got done %b rdata %h required 1 600df00d", dm_done_o, dm_rdata_o); n_err++;
    end
    n_cmp++;
    dm_req_i = 1'b0;
    step();
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    if_req_i = 1'b1; if_addr_i = 32'h80;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (mem_req_o !== 1'b1 || err_o !== 1'b0) begin
        $display("FAIL to_wait_c%0d: got req %b err %b required 1 0", c, mem_req_o, err_o); n_err++;
      end
      n_cmp++;
    end
    step();  // after ISSUE cycle 8 with no ack
    if (mem_req_o !== 1'b0 || err_o !== 1'b1 || if_done_o !== 1'b1 || if_rdata_o !== 32'h7) begin
      $display("FAIL to_expire: got req %b err %b done %b rdata %h required 0 1 1 00000007",
               mem_req_o, err_o, if_done_o, if_rdata_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0;
    step();
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      $display("FAIL to_err_pulse: got err %b busy %b required 0 0", err_o, busy_o); n_err++;
    end
    n_cmp++;
    // Ack in the timeout cycle wins.
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h84;
    for (int c = 1; c <= 8; c++) step();
    mem_ack_i = 1'b1; mem_rdata_i = 32'h99;
    step();
    mem_ack_i = 1'b0;
    if (dm_done_o !== 1'b1 || err_o !== 1'b0 || dm_rdata_o !== 32'h99) begin
      $display("FAIL to_ack_wins: got done %b err %b rdata %h required 1 0 00000099", dm_done_o, err_o, dm_rdata_o); n_err++;
    end
    n_cmp++;
    dm_req_i = 1'b0;
    step();
  endtask
`else
  task automatic test_timeout();
    if_req_i = 1'b1; if_addr_i = 32'h80;
    repeat (12) step();
    if (mem_req_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b1) begin
      $display("FAIL noto_wait: got req %b err %b busy %b required 1 0 1", mem_req_o, err_o, busy_o); n_err++;
    end
    n_cmp++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h00C0FFEE;
    step();
    mem_ack_i = 1'b0;
    if (if_done_o !== 1'b1 || err_o !== 1'b0 || if_rdata_o !== 32'h00C0FFEE) begin
      $display("FAIL noto_done: got done %b err %b rdata %h required 1 0 00c0ffee", if_done_o, err_o, if_rdata_o); n_err++;
    end
    n_cmp++;
    if_req_i = 1'b0;
    step();
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; if_cancel_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    step();
    step();
    test_reset();
    rst_i = 1'b0;
    step();
    test_reset_mid_issue();
    test_if_read();
    test_dm_priority();
    test_starvation();
    test_cancel();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
